// File: rtl/vga_pkg.sv
// Shared types and defaults for the VGA fetch path.
//   vga_scale_t   : pixel replication factor (1x / 2x / 4x)
//   fetch_state_t : fetch counter state
//   VGA_MAX_X/Y   : default maximum active area
//   scale_decode  : raw 2-bit config -> scale (the unused code 3 maps to 1x)
//   scale_mask    : low-bit mask whose all-zero test marks a new source pixel
package vga_pkg;

    localparam int VGA_MAX_X = 640;
    localparam int VGA_MAX_Y = 480;

    typedef enum logic [1:0] {
        SCALE_1X = 2'd0,
        SCALE_2X = 2'd1,
        SCALE_4X = 2'd2
    } vga_scale_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } fetch_state_t;

    function automatic vga_scale_t scale_decode(input logic [1:0] raw);
        vga_scale_t s;
        case (raw)
            2'd1:    s = SCALE_2X;
            2'd2:    s = SCALE_4X;
            default: s = SCALE_1X;
        endcase
        return s;
    endfunction

    function automatic logic [1:0] scale_mask(input vga_scale_t s);
        logic [1:0] m;
        case (s)
            SCALE_2X: m = 2'b01;
            SCALE_4X: m = 2'b11;
            default:  m = 2'b00;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/vga_addr_gen.sv
// Framebuffer source address generator with pixel/line replication.
//   clock, reset : system clock, synchronous active-high reset
//   load         : start of frame; row_base and src_addr take load_base
//   load_base    : framebuffer base address
//   step_pixel   : advance within a line
//   step_line    : advance to the next line (not issued on the last pixel)
//   next_x_lo    : low bits of the pixel_x being advanced to
//   next_y_lo    : low bits of the pixel_y being advanced to
//   scale        : latched replication factor
//   stride       : latched source pixels per source row
//   src_addr     : framebuffer address of the current pixel
module vga_addr_gen
    import vga_pkg::*;
#(
    parameter int ADDR_W = 26
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_base,
    input  logic              step_pixel,
    input  logic              step_line,
    input  logic [1:0]        next_x_lo,
    input  logic [1:0]        next_y_lo,
    input  vga_scale_t        scale,
    input  logic [15:0]       stride,
    output logic [ADDR_W-1:0] src_addr
);

    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] row_base_inc;
    logic [1:0]        mask;
    logic              new_src_col;
    logic              new_src_row;

    assign mask         = scale_mask(scale);
    assign row_base_inc = row_base + ADDR_W'(stride);
    // A new source pixel/row begins whenever the replicated coordinate
    // crosses a multiple of the scale factor.
    assign new_src_col  = ((next_x_lo & mask) == 2'b00);
    assign new_src_row  = ((next_y_lo & mask) == 2'b00);

    always_ff @(posedge clock) begin
        if (reset) begin
            row_base <= '0;
            src_addr <= '0;
        end else if (load) begin
            row_base <= load_base;
            src_addr <= load_base;
        end else if (step_line) begin
            if (new_src_row) begin
                row_base <= row_base_inc;
                src_addr <= row_base_inc;
            end else begin
                // Replicated line: rewind to the start of the same source row.
                src_addr <= row_base;
            end
        end else if (step_pixel && new_src_col) begin
            src_addr <= src_addr + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/vga_fetch_counter.sv
// Active-area pixel fetch counter with configurable size and replication.
//   clock, reset      : system clock, synchronous active-high reset
//   new_frame         : one-cycle pulse, (re)starts a frame and latches cfg_*
//   fifo_full         : downstream FIFO full, stalls the current slot
//   cache_ready       : pixel cache can accept a fetch
//   cfg_width/height  : active size, 0 or oversize selects the maximum
//   cfg_scale         : 0=1x, 1=2x, 2=4x, 3=1x
//   cfg_base/stride   : framebuffer base and source row pitch
//   pixel_x/pixel_y   : screen coordinates of the current pixel
//   src_addr          : framebuffer address of the current pixel
//   next_pixel/line   : one-cycle advance pulses
//   frame_done        : one-cycle pulse on the last pixel of the frame
//   busy              : high while ACTIVE
//
// state  | meaning
// IDLE   | after reset, no fetches
// ACTIVE | walking the active area, one slot every DIV cycles
// DONE   | frame finished, outputs held until new_frame
module vga_fetch_counter
    import vga_pkg::*;
#(
    parameter int MAX_X  = VGA_MAX_X,
    parameter int MAX_Y  = VGA_MAX_Y,
    parameter int DIV    = 2,
    parameter int XW     = 10,
    parameter int YW     = 10,
    parameter int ADDR_W = 26
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              new_frame,
    input  logic              fifo_full,
    input  logic              cache_ready,
    input  logic [XW-1:0]     cfg_width,
    input  logic [YW-1:0]     cfg_height,
    input  logic [1:0]        cfg_scale,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [15:0]       cfg_stride,
    output logic [XW-1:0]     pixel_x,
    output logic [YW-1:0]     pixel_y,
    output logic [ADDR_W-1:0] src_addr,
    output logic              next_pixel,
    output logic              next_line,
    output logic              frame_done,
    output logic              busy
);

    localparam int              DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [XW-1:0]    MAX_X_W  = XW'(MAX_X);
    localparam logic [YW-1:0]    MAX_Y_W  = YW'(MAX_Y);

    fetch_state_t     state, state_nx;
    logic [DIV_W-1:0] div, div_nx;
    logic [XW-1:0]    x_nx, x_plus, width_q, width_in;
    logic [YW-1:0]    y_nx, y_plus, height_q, height_in;
    vga_scale_t       scale_q;
    logic [15:0]      stride_q;
    logic             np_nx, nl_nx, fd_nx;
    logic             advance, at_eol, at_last;

    assign width_in  = (cfg_width == '0 || cfg_width > MAX_X_W) ? MAX_X_W : cfg_width;
    assign height_in = (cfg_height == '0 || cfg_height > MAX_Y_W) ? MAX_Y_W : cfg_height;

    assign x_plus  = pixel_x + XW'(1);
    assign y_plus  = pixel_y + YW'(1);
    assign at_eol  = (pixel_x == width_q - XW'(1));
    assign at_last = at_eol && (pixel_y == height_q - YW'(1));
    // Throttles are only looked at in the div==0 slot; a stall forfeits it.
    assign advance = (state == ACTIVE) && (div == '0) && !fifo_full && cache_ready;
    assign busy    = (state == ACTIVE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        div_nx   = div;
        x_nx     = pixel_x;
        y_nx     = pixel_y;
        np_nx    = 1'b0;
        nl_nx    = 1'b0;
        fd_nx    = 1'b0;
        if (new_frame) begin
            state_nx = ACTIVE;
            div_nx   = '0;
            x_nx     = '0;
            y_nx     = '0;
            np_nx    = 1'b1;
        end else begin
            case (state)
                ACTIVE: begin
                    div_nx = (div == DIV_LAST) ? '0 : div + DIV_W'(1);
                    if (advance) begin
                        np_nx = 1'b1;
                        if (at_eol) begin
                            x_nx  = '0;
                            nl_nx = 1'b1;
                            if (at_last) begin
                                // pixel_y parks at height so the consumer sees
                                // an out-of-range line after the last pixel.
                                y_nx     = height_q;
                                fd_nx    = 1'b1;
                                state_nx = DONE;
                                div_nx   = '0;
                            end else begin
                                y_nx = y_plus;
                            end
                        end else begin
                            x_nx = x_plus;
                        end
                    end
                end
                default: div_nx = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div        <= '0;
            pixel_x    <= '0;
            pixel_y    <= '0;
            next_pixel <= 1'b0;
            next_line  <= 1'b0;
            frame_done <= 1'b0;
            width_q    <= MAX_X_W;
            height_q   <= MAX_Y_W;
            scale_q    <= SCALE_1X;
            stride_q   <= '0;
        end else begin
            div        <= div_nx;
            pixel_x    <= x_nx;
            pixel_y    <= y_nx;
            next_pixel <= np_nx;
            next_line  <= nl_nx;
            frame_done <= fd_nx;
            if (new_frame) begin
                width_q  <= width_in;
                height_q <= height_in;
                scale_q  <= scale_decode(cfg_scale);
                stride_q <= cfg_stride;
            end
        end
    end

    vga_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clock      (clock),
        .reset      (reset),
        .load       (new_frame),
        .load_base  (cfg_base),
        .step_pixel (advance && !at_eol),
        .step_line  (advance && at_eol && !at_last),
        .next_x_lo  (x_plus[1:0]),
        .next_y_lo  (y_plus[1:0]),
        .scale      (scale_q),
        .stride     (stride_q),
        .src_addr   (src_addr)
    );

endmodule
